// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage RV64I/Zba core.
// Produces stall/flush controls for F, F/D, D/E and E/M, E-stage forwarding
// selects, and sequences load-use bubbles and multi-cycle E-stage operations.
// Control outputs are combinational from inputs and the registered state.
module hazard_sequencer #(
  parameter int unsigned LOAD_USE_STALLS = 1,
  parameter int unsigned EX_TIMEOUT      = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rs1_E,
  input  logic [4:0] Rs2_E,
  input  logic [4:0] Rd_E,
  input  logic [4:0] Rd_M,
  input  logic [4:0] Rd_W,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic [1:0] ResultSrc_E,
  input  logic       PCSrc_E,
  input  logic       MultiCycle_E,
  input  logic       ExDone,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Stall_E,
  output logic       Flush_D,
  output logic       Flush_E,
  output logic       Flush_M,
  output logic [1:0] ForwardA_E,
  output logic [1:0] ForwardB_E,
  output logic       ExStart,
  output logic       Busy,
  output logic       ExTimeout
);

  localparam int unsigned WW = $clog2(EX_TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(EX_TIMEOUT);
  localparam logic [2:0]    LU_EXTRA  = 3'(LOAD_USE_STALLS - 1);

  typedef enum logic [1:0] {RUN, LU_STALL, EX_WAIT} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [WW-1:0] wdog;
  logic          timeout_q;
  logic          lu_hz;

  assign lu_hz = (ResultSrc_E == 2'b01) && (Rd_E != 5'd0) &&
                 ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // M stage result has priority over W stage; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWrite_M && (Rd_M != 5'd0) && (Rd_M == rs))      fwd_sel = 2'b10;
    else if (RegWrite_W && (Rd_W != 5'd0) && (Rd_W == rs)) fwd_sel = 2'b01;
    else                                                  fwd_sel = 2'b00;
  endfunction

  // Combinational hazard controls from inputs and current state; forced low in reset.
  always_comb begin
    Stall_F    = 1'b0;
    Stall_D    = 1'b0;
    Stall_E    = 1'b0;
    Flush_D    = 1'b0;
    Flush_E    = 1'b0;
    Flush_M    = 1'b0;
    ExStart    = 1'b0;
    Busy       = 1'b0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (!rst) begin
      ForwardA_E = fwd_sel(Rs1_E);
      ForwardB_E = fwd_sel(Rs2_E);
      Busy       = (state != RUN);
      unique case (state)
        RUN: begin
          if (PCSrc_E) begin
            Flush_D = 1'b1;
            Flush_E = 1'b1;
          end else if (MultiCycle_E) begin
            ExStart = 1'b1;
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Flush_M = 1'b1;
          end else if (lu_hz) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
          end
        end
        LU_STALL: begin
          Stall_F = 1'b1;
          Stall_D = 1'b1;
          Flush_E = 1'b1;
        end
        EX_WAIT: begin
          // Release on ExDone or on watchdog expiry; otherwise hold the front end.
          if (!ExDone && (wdog != WDOG_MAX)) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Flush_M = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ExTimeout = timeout_q;

  // State, bubble counter, watchdog and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (PCSrc_E) begin
            state <= RUN;
          end else if (MultiCycle_E) begin
            wdog  <= WW'(1);
            state <= EX_WAIT;
          end else if (lu_hz && (LOAD_USE_STALLS > 1)) begin
            cnt   <= LU_EXTRA;
            state <= LU_STALL;
          end
        end
        LU_STALL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RUN;
        end
        EX_WAIT: begin
          if (ExDone) begin
            state <= RUN;
          end else if (wdog == WDOG_MAX) begin
            timeout_q <= 1'b1;
            state     <= RUN;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Testbench for hazard_sequencer: two instances (LOAD_USE_STALLS/EX_TIMEOUT of
// 1/64 and 3/8) share stimulus and are compared against a cycle reference model.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] Rs1_D = '0, Rs2_D = '0, Rs1_E = '0, Rs2_E = '0;
  logic [4:0] Rd_E = '0, Rd_M = '0, Rd_W = '0;
  logic       RegWrite_M = 1'b0, RegWrite_W = 1'b0;
  logic [1:0] ResultSrc_E = '0;
  logic       PCSrc_E = 1'b0, MultiCycle_E = 1'b0, ExDone = 1'b0;

  logic       sf[2], sd[2], se[2], fd[2], fe[2], fm[2], xs[2], bz[2], to[2];
  logic [1:0] fa[2], fb[2];
  logic [12:0] obs[2];
  logic [12:0] exp_v[2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: remaining extra load-use bubbles, cycles spent
  // waiting on the multi-cycle unit (0 = not waiting), sticky timeout.
  int unsigned lus[2] = '{1, 3};
  int unsigned lim[2] = '{64, 8};
  int unsigned lu_left[2] = '{0, 0};
  int unsigned ex_cyc[2]  = '{0, 0};
  bit          tmo[2]     = '{0, 0};
  int unsigned n_lu[2], n_ex[2];
  bit          n_to[2];

  always #5 clk = ~clk;

  hazard_sequencer #(.LOAD_USE_STALLS(1), .EX_TIMEOUT(64)) u_a (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .MultiCycle_E(MultiCycle_E), .ExDone(ExDone),
    .Stall_F(sf[0]), .Stall_D(sd[0]), .Stall_E(se[0]), .Flush_D(fd[0]), .Flush_E(fe[0]),
    .Flush_M(fm[0]), .ForwardA_E(fa[0]), .ForwardB_E(fb[0]), .ExStart(xs[0]), .Busy(bz[0]),
    .ExTimeout(to[0]));

  hazard_sequencer #(.LOAD_USE_STALLS(3), .EX_TIMEOUT(8)) u_b (
    .clk(clk), .rst(rst), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E), .MultiCycle_E(MultiCycle_E), .ExDone(ExDone),
    .Stall_F(sf[1]), .Stall_D(sd[1]), .Stall_E(se[1]), .Flush_D(fd[1]), .Flush_E(fe[1]),
    .Flush_M(fm[1]), .ForwardA_E(fa[1]), .ForwardB_E(fb[1]), .ExStart(xs[1]), .Busy(bz[1]),
    .ExTimeout(to[1]));

  always_comb begin
    for (int k = 0; k < 2; k++)
      obs[k] = {sf[k], sd[k], se[k], fd[k], fe[k], fm[k], fa[k], fb[k], xs[k], bz[k], to[k]};
  end

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWrite_M && Rd_M == rs) return 2'b10;
    if (RegWrite_W && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Let inputs settle, then compute expected outputs and next model state.
  task automatic settle();
    bit lu;
    logic s_f, s_d, s_e, f_d, f_e, f_m, x_s, b_z;
    #1;
    lu = (ResultSrc_E == 2'b01) && (Rd_E != 0) && (Rd_E == Rs1_D || Rd_E == Rs2_D);
    for (int k = 0; k < 2; k++) begin
      {s_f, s_d, s_e, f_d, f_e, f_m, x_s, b_z} = '0;
      n_lu[k] = lu_left[k]; n_ex[k] = ex_cyc[k]; n_to[k] = tmo[k];
      if (rst) begin
        n_lu[k] = 0; n_ex[k] = 0; n_to[k] = 0;
        exp_v[k] = '0;
      end else begin
        if (ex_cyc[k] > 0) begin
          b_z = 1;
          if (ExDone) n_ex[k] = 0;
          else if (ex_cyc[k] == lim[k]) begin n_ex[k] = 0; n_to[k] = 1; end
          else begin {s_f, s_d, s_e, f_m} = '1; n_ex[k] = ex_cyc[k] + 1; end
        end else if (lu_left[k] > 0) begin
          b_z = 1; {s_f, s_d, f_e} = '1; n_lu[k] = lu_left[k] - 1;
        end else if (PCSrc_E) begin
          {f_d, f_e} = '1;
        end else if (MultiCycle_E) begin
          {x_s, s_f, s_d, s_e, f_m} = '1; n_ex[k] = 1;
        end else if (lu) begin
          {s_f, s_d, f_e} = '1; n_lu[k] = lus[k] - 1;
        end
        exp_v[k] = {s_f, s_d, s_e, f_d, f_e, f_m, ref_fwd(Rs1_E), ref_fwd(Rs2_E), x_s, b_z, tmo[k]};
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      lu_left[k] = n_lu[k]; ex_cyc[k] = n_ex[k]; tmo[k] = n_to[k];
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W} = '0;
    {RegWrite_M, RegWrite_W, PCSrc_E, MultiCycle_E, ExDone} = '0;
    ResultSrc_E = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; MultiCycle_E = 1'b1; RegWrite_M = 1'b1; Rd_M = 5'd3; Rs1_E = 5'd3;
    settle();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (obs[k] !== 13'd0) begin
        n_fail++; $display("FAIL reset[%0d] outputs got %b want 0", k, obs[k]);
      end
    end
    advance();
    idle_inputs();
    rst = 1'b0;
    settle();
    advance();
  endtask

  task automatic test_forwarding();
    logic [1:0] want[3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      Rd_M = 5'd7; Rd_W = 5'd7; RegWrite_W = 1'b1; Rs1_E = 5'd7; Rs2_E = 5'd7;
      RegWrite_M = (i == 0);
      if (i == 2) Rs1_E = 5'd0;
      settle();
      n_tests++;
      if (fa[0] !== want[i]) begin
        n_fail++; $display("FAIL fwdA case%0d got %b want %b", i, fa[0], want[i]);
      end
      n_tests++;
      if (obs[1] !== exp_v[1]) begin
        n_fail++; $display("FAIL fwd_model case%0d got %b want %b", i, obs[1], exp_v[1]);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    bit want_a[4] = '{1, 0, 0, 0};
    bit want_b[4] = '{1, 1, 1, 0};
    bit busy_b[4] = '{0, 1, 1, 0};
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      Rs1_D = 5'd5; Rs2_D = 5'd9;
      if (c == 0) begin ResultSrc_E = 2'b01; Rd_E = 5'd5; end
      settle();
      n_tests++;
      if ({sf[0], sd[0], fe[0]} !== {3{want_a[c]}}) begin
        n_fail++; $display("FAIL lu1 cyc%0d got %b want %b", c, {sf[0], sd[0], fe[0]}, {3{want_a[c]}});
      end
      n_tests++;
      if ({sf[1], sd[1], fe[1], bz[1]} !== {{3{want_b[c]}}, busy_b[c]}) begin
        n_fail++; $display("FAIL lu3 cyc%0d got %b want %b", c, {sf[1], sd[1], fe[1], bz[1]},
                           {{3{want_b[c]}}, busy_b[c]});
      end
      advance();
    end
    idle_inputs();
    ResultSrc_E = 2'b01; Rd_E = 5'd0; Rs1_D = 5'd0;
    settle();
    n_tests++;
    if (obs[1] !== exp_v[1] || sf[1] !== 1'b0) begin
      n_fail++; $display("FAIL lu_x0 got %b want %b", obs[1], exp_v[1]);
    end
    advance();
  endtask

  task automatic test_branch();
    idle_inputs();
    PCSrc_E = 1'b1; ResultSrc_E = 2'b01; Rd_E = 5'd4; Rs2_D = 5'd4;
    settle();
    n_tests++;
    if ({fd[1], fe[1], sf[1], sd[1]} !== 4'b1100 || obs[1] !== exp_v[1]) begin
      n_fail++; $display("FAIL branch got %b want %b", obs[1], exp_v[1]);
    end
    advance();
    idle_inputs();
    settle();
    n_tests++;
    if (bz[1] !== 1'b0 || sf[1] !== 1'b0) begin
      n_fail++; $display("FAIL branch_after busy=%b stall=%b want 0 0", bz[1], sf[1]);
    end
    advance();
  endtask

  task automatic test_multicycle();
    int starts = 0;
    int stalls = 0;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      MultiCycle_E = (c <= 5); Rs1_E = 5'd2; RegWrite_M = 1'b1; Rd_M = 5'd2;
      ExDone = (c == 5) || (c == 6);
      settle();
      starts += xs[0];
      stalls += se[0];
      n_tests++;
      if (obs[0] !== exp_v[0]) begin
        n_fail++; $display("FAIL mc cyc%0d got %b want %b", c, obs[0], exp_v[0]);
      end
      advance();
    end
    n_tests++;
    if (starts != 1 || stalls != 5) begin
      n_fail++; $display("FAIL mc_counts starts=%0d stalls=%0d want 1 5", starts, stalls);
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 11; c++) begin
      idle_inputs();
      MultiCycle_E = (c <= 8);
      settle();
      n_tests++;
      if (obs[1] !== exp_v[1] || obs[0] !== exp_v[0]) begin
        n_fail++; $display("FAIL tmo cyc%0d got %b/%b want %b/%b", c, obs[0], obs[1], exp_v[0], exp_v[1]);
      end
      if (c == 8 || c == 9) begin
        n_tests++;
        if ({to[1], se[1]} !== {c == 9, 1'b0}) begin
          n_fail++; $display("FAIL tmo_edge cyc%0d got to=%b stall=%b want %b 0", c, to[1], se[1], c == 9);
        end
      end
      advance();
    end
    rst = 1'b1; MultiCycle_E = 1'b1; Rd_M = 5'd6; RegWrite_M = 1'b1; Rs2_E = 5'd6;
    settle();
    n_tests++;
    if (obs[0] !== 13'd0 || obs[1] !== 13'd0) begin
      n_fail++; $display("FAIL rst_midwait got %b/%b want 0", obs[0], obs[1]);
    end
    advance();
    idle_inputs();
    rst = 1'b0;
    settle();
    n_tests++;
    if (bz[0] !== 1'b0 || to[1] !== 1'b0) begin
      n_fail++; $display("FAIL post_rst busy=%b tmo=%b want 0 0", bz[0], to[1]);
    end
    advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      Rs1_D = 5'($urandom_range(0, 3)); Rs2_D = 5'($urandom_range(0, 3));
      Rs1_E = 5'($urandom_range(0, 3)); Rs2_E = 5'($urandom_range(0, 3));
      Rd_E = 5'($urandom_range(0, 3)); Rd_M = 5'($urandom_range(0, 3)); Rd_W = 5'($urandom_range(0, 3));
      RegWrite_M = 1'($urandom); RegWrite_W = 1'($urandom);
      ResultSrc_E = 2'($urandom);
      PCSrc_E = ($urandom_range(0, 9) == 0);
      MultiCycle_E = ($urandom_range(0, 7) == 0);
      ExDone = ($urandom_range(0, 11) == 0);
      settle();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (obs[k] !== exp_v[k]) begin
          n_fail++; $display("FAIL rand[%0d] cyc%0d got %b want %b", k, c, obs[k], exp_v[k]);
        end
      end
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_multicycle();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
